// File: rtl/uart_ctrl.sv
// UART peripheral controller: bus register file, RX FIFO, TX handshake FSM and
// level interrupt. Baud-domain status flags are brought into clk via 2-flop
// synchronisers.
module uart_ctrl #(
  parameter int unsigned RX_DEPTH = 4,
  parameter logic [7:0]  ADDR_TXD = 8'h18,
  parameter logic [7:0]  ADDR_RXD = 8'h1C,
  parameter logic [7:0]  ADDR_CON = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  input  logic [7:0]  rx_data,
  input  logic        rx_status,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_status
);

  localparam int unsigned PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StWaitRdy, StReq, StSend} tx_state_e;

  tx_state_e      state;
  logic [1:0]     rx_sync, tx_sync;
  logic           rx_prev;
  logic           rx_s, tx_s, push;
  logic [7:0]     mem [RX_DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic           rx_ne, full, pop, push_ok, ovf_set;
  logic           wr_txd, wr_con, tx_start, tx_done_set, tx_busy;
  logic           rx_ie, tx_ie, rx_ovf, tx_done;
  logic [31:0]    con_val;
  logic           unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign rx_s = rx_sync[1];
  assign tx_s = tx_sync[1];
  // One push per rising edge of the synchronised frame-valid pulse
  assign push = rx_s & ~rx_prev;

  assign rx_ne   = (count != '0);
  assign full    = (count == CW'(RX_DEPTH));
  assign pop     = rd && (addr == ADDR_RXD) && rx_ne;
  // A same-cycle pop frees a slot, so a full FIFO can still accept the push
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  assign wr_txd      = wr && (addr == ADDR_TXD);
  assign wr_con      = wr && (addr == ADDR_CON);
  assign tx_busy     = (state != StIdle);
  assign tx_start    = wr_txd && !tx_busy;
  assign tx_done_set = (state == StSend) && tx_s;

  assign con_val = {26'b0, tx_done, rx_ovf, tx_busy, rx_ne, tx_ie, rx_ie};

  // Status synchronisers and edge-detect history
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_sync <= '0;
      tx_sync <= '0;
      rx_prev <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx_status};
      tx_sync <= {tx_sync[0], tx_status};
      rx_prev <= rx_s;
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= rx_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // TX handshake FSM with registered tx_en and held tx_data
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= StIdle;
      tx_data <= 8'h00;
      tx_en   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          tx_en <= 1'b0;
          if (tx_start) begin
            tx_data <= wdata[7:0];
            state   <= StWaitRdy;
          end
        end
        StWaitRdy: begin
          if (tx_s) begin
            tx_en <= 1'b1;
            state <= StReq;
          end
        end
        StReq: begin
          if (!tx_s) begin
            tx_en <= 1'b0;
            state <= StSend;
          end
        end
        StSend: begin
          tx_en <= 1'b0;
          if (tx_s) state <= StIdle;
        end
        default: begin
          tx_en <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

  // CON bits: rw enables, sticky flags where a set beats a same-cycle W1C
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_ie   <= 1'b0;
      tx_ie   <= 1'b0;
      rx_ovf  <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      if (wr_con) begin
        rx_ie <= wdata[0];
        tx_ie <= wdata[1];
      end
      if (ovf_set)                  rx_ovf <= 1'b1;
      else if (wr_con && wdata[4])  rx_ovf <= 1'b0;
      if (tx_done_set)              tx_done <= 1'b1;
      else if (wr_con && wdata[5])  tx_done <= 1'b0;
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (rx_ie & rx_ne) | (tx_ie & tx_done);
    end
  end

  // Read mux reflects pre-edge state, so rd+wr returns the old value
  always_comb begin
    rdata = 32'h0;
    if (reset && rd) begin
      if (addr == ADDR_TXD) begin
        rdata = {24'b0, tx_data};
      end else if (addr == ADDR_RXD) begin
        if (rx_ne) rdata = {24'b0, mem[rptr]};
      end else if (addr == ADDR_CON) begin
        rdata = con_val;
      end
    end
  end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
- Memory-mapped UART peripheral controller on the CPU peripheral bus.
- Sequences the baud-domain receiver and transmitter and buffers received bytes in an RX FIFO.
- Exposes TXD, RXD and CON registers to the pipeline and raises a level interrupt.
- rx_status and tx_status come from the slower baudrate_clk domain; both are synchronised into clk.

Parameters:
- RX_DEPTH, 4, RX FIFO entries; power of two, minimum 2.
- ADDR_TXD, 8'h18, TXD register offset.
- ADDR_RXD, 8'h1C, RXD register offset.
- ADDR_CON, 8'h20, CON register offset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- addr  in  8  bus address low byte.
- rd  in  1  read strobe, one cycle per access.
- wr  in  1  write strobe, one cycle per access.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational from addr/rd.
- irq  out  1  level interrupt request.
- rx_data  in  8  byte from receiver, stable while rx_status high.
- rx_status  in  1  receiver frame-valid pulse (baud domain).
- tx_data  out  8  byte to transmitter.
- tx_en  out  1  transmit request to transmitter.
- tx_status  in  1  transmitter idle flag, 1 = idle (baud domain).

Behaviour:
Reset (reset low at a clk edge):
- FIFO emptied; pointers and count = 0.
- CON bits = 0; tx_data = 0; tx_en = 0.
- TX FSM = IDLE; synchronisers cleared.
- irq = 0; rdata = 0.
- Reset mid-frame or mid-transmit abandons the operation; no byte is pushed or resent.

Synchronisation:
- rx_status and tx_status each pass through a 2-flop synchroniser.
- RX push event = rising edge of synced rx_status: exactly one push per pulse, regardless of pulse length in clk cycles.
- rx_data is sampled on the push cycle.

RX FIFO:
- Push when not full: write entry, count+1.
- Push when full: byte dropped, CON.rx_ovf set to 1 (sticky).
- Pop = rd with addr==ADDR_RXD while not empty: rdata = {24'b0, head} in the same cycle, head advances at the edge.
- Pop when empty: rdata = 0, no state change.
- Simultaneous push and pop: both performed, count unchanged.
- Simultaneous push and pop when full: pop frees space, push accepted, no overflow.
- Pointers wrap modulo RX_DEPTH; count is log2(RX_DEPTH)+1 bits.

CON register:
- bit0 rx_ie: rw.
- bit1 tx_ie: rw.
- bit2 rx_ne: ro, count!=0.
- bit3 tx_busy: ro, FSM!=IDLE.
- bit4 rx_ovf: sticky, write 1 clears.
- bit5 tx_done: sticky, write 1 clears.
- Other bits read 0; writes to them are ignored.
- If a set event and a W1C clear of the same bit occur in the same cycle, the set wins.

TXD register:
- Write with tx_busy=0: tx_data <= wdata[7:0], FSM IDLE->WAIT_RDY.
- Write with tx_busy=1: ignored (no queueing, no flag).
- Read returns {24'b0, tx_data}.

TX FSM:
- IDLE: tx_en=0.
- WAIT_RDY: when synced tx_status=1, go to REQ.
- REQ: tx_en=1; hold until synced tx_status=0, then go to SEND.
- SEND: tx_en=0; when synced tx_status=1, set tx_done and go to IDLE.
- tx_data is held constant from the TXD write until return to IDLE.

irq:
- irq = (rx_ie & rx_ne) | (tx_ie & tx_done), registered (one-cycle delay from the flag change).

Bus decode:
- rd or wr to other offsets: rdata = 0, no effect.
- rd and wr asserted in the same cycle: the write takes effect and the read returns the pre-write value.

Test Plan:
- Reset, then read CON -> rdata = 0, irq = 0, tx_en = 0.
- Three rx_status pulses carrying 8'h41, 8'h42, 8'h43 (each 16 clk long), then three RXD reads -> rdata 0x41, 0x42, 0x43 in order; rx_ne = 0 after the third read; a fourth read returns 0.
- Five pushes with RX_DEPTH=4 -> first four bytes retained, rx_ovf = 1; write CON 0x10 -> rx_ovf = 0.
- FIFO full, pop and push in the same cycle -> count stays 4, no overflow, wrap ordering correct.
- Write TXD 0x55 with a tx_status model (idle, busy after tx_en, idle 100 clk later):
  - tx_en high until busy observed, tx_data = 0x55 throughout;
  - tx_done = 1 on completion; with tx_ie = 1, irq = 1;
  - a second TXD write while busy is ignored.
- Assert reset low while in REQ and with FIFO non-empty -> next cycle tx_en = 0, count = 0, CON = 0.
